ssd_scan_ctrl: RTL and testbench
================================

# ssd_scan_ctrl

Time-multiplexed four-digit seven-segment display driver. It sits directly downstream of the lab02_2 decode stage. It takes the packed 4-bit digit values that stage produces, captures them on a load strobe, and scans them one digit at a time onto the board's common-anode display. The display's segment and digit-enable lines are active-low.

## Interface
- REFRESH_CNT, 100000, clocks per digit slot (1 kHz per digit at 100 MHz); legal range ≥ 2
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- value  in  16  digits packed: [3:0]=digit0 (rightmost) … [15:12]=digit3
- load  in  1  capture strobe: value/dp/lzb sampled into shadow registers while high
- dp  in  4  decimal point request per digit, 1=on
- lzb  in  1  leading-zero blanking enable
- ssd_ctl  out  4  digit enables, active-low; bit n = digit n
- segs  out  8  segment drive, active-low, order {dp,g,f,e,d,c,b,a}

## Operation
- Shadow registers: on each rising edge with load=1, capture sh_value←value, sh_dp←dp and sh_lzb←lzb. Otherwise hold. The scan uses only shadow data, so the display never tears mid-frame.
- Prescaler: cnt counts 0…REFRESH_CNT-1 and wraps to 0. When cnt=REFRESH_CNT-1, idx advances 0→1→2→3→0 (2-bit wrap).
- Digit select: ssd_ctl_next has exactly one 0, at position idx.
- Digit decode (active-low {g..a}):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - Values are hex with bit 7 (dp) = 1.
  - sh_dp[idx]=1 clears bit 7.
- Leading-zero blanking:
  - Applies only when sh_lzb=1.
  - Digit n (n=3,2,1) is blanked if it and every higher digit are 0.
  - Digit 0 is never blanked.
  - A blanked digit drives segs=8'hFF, which also suppresses the dp request.
  - ssd_ctl is still asserted for a blanked digit; the scan order is unchanged.
- Outputs are registered: ssd_ctl and segs are computed from the current idx and shadow registers and registered every clock.

## Timing
- Reset (rst_n=0, asynchronous): ssd_ctl=4'hF, segs=8'hFF, cnt=0, idx=0, shadow registers all 0.
- First edge after reset release: ssd_ctl=4'b1110, segs=C0 (digit0=0).
- Load latency:
  - Edge k with load=1 updates the shadow registers.
  - Edge k+1 reflects the new data on segs, if the selected digit was affected.
- Digit dwell: each ssd_ctl pattern holds for exactly REFRESH_CNT clocks. A full frame is 4×REFRESH_CNT clocks.
- Digit switch:
  - idx changes on the edge where cnt=REFRESH_CNT-1.
  - ssd_ctl and segs change together one edge later.
  - No cycle ever has two enables low or a mismatched segment pattern.
- load held high continuously: the shadow tracks value every clock, which is legal.
- load coincident with a digit switch: both take effect. The first cycle of the new digit shows the newly loaded data.
- Reset mid-frame: outputs blank immediately (asynchronously). Scanning restarts at digit0 with shadow=0.

## Test plan
- Reset check:
  - Stimulus: assert rst_n=0 mid-scan at a non-edge time.
  - Required: ssd_ctl=F and segs=FF immediately.
  - Required after release: first edge gives ssd_ctl=E, segs=C0.
- Hex sweep (REFRESH_CNT=4):
  - Stimulus: load value=16'h3210, then 16'h7654, 16'hBA98, 16'hFEDC.
  - Required: every segs pattern matches the 16-entry table on the correct digit.
  - Required: ctl sequence E,D,B,7, each held 4 clocks.
- Decimal point:
  - Stimulus: load value=16'h0000, dp=4'b0100.
  - Required: digit2 segs=40, other digits C0.
- Leading-zero blanking:
  - Stimulus: load value=16'h0050, lzb=1.
  - Required: digit3=FF, digit2=FF, digit1=92, digit0=C0.
  - Stimulus: load value=16'h0000, lzb=1.
  - Required: only digit0 shows C0.
- Tear-free load:
  - Stimulus: change value without load.
  - Required: display unchanged.
  - Stimulus: pulse load on the edge where cnt=3.
  - Required: the next digit slot shows the new data on its first cycle.
- Exclusivity:
  - Stimulus: run random loads for 1000 clocks.
  - Required: ssd_ctl is always one-hot-low (or F only during reset).
  - Required: dwell is always exactly REFRESH_CNT clocks.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment scan driver (common anode, active-low).
// Captures digit data into shadow registers on load and scans them tear-free.
module ssd_scan_ctrl #(
    parameter int unsigned REFRESH_CNT = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp,
    input  logic        lzb,
    output logic [3:0]  ssd_ctl,
    output logic [7:0]  segs
);

    localparam int unsigned CW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_CNT - 1);

    logic [15:0]   sh_value_q, sh_value_d;
    logic [3:0]    sh_dp_q, sh_dp_d;
    logic          sh_lzb_q, sh_lzb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    ssd_ctl_q, ssd_ctl_d;
    logic [7:0]    segs_q, segs_d;

    logic [3:0]    nib;
    logic [6:0]    seg7;
    logic          blank;

    always_comb begin
        sh_value_d = sh_value_q;
        sh_dp_d    = sh_dp_q;
        sh_lzb_d   = sh_lzb_q;
        if (load) begin
            sh_value_d = value;
            sh_dp_d    = dp;
            sh_lzb_d   = lzb;
        end

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        // A digit blanks only when it and every more-significant digit are zero.
        nib   = 4'h0;
        blank = 1'b0;
        case (idx_q)
            2'd0: nib = sh_value_q[3:0];
            2'd1: begin nib = sh_value_q[7:4];   blank = sh_lzb_q && (sh_value_q[15:4] == '0); end
            2'd2: begin nib = sh_value_q[11:8];  blank = sh_lzb_q && (sh_value_q[15:8] == '0); end
            default: begin nib = sh_value_q[15:12]; blank = sh_lzb_q && (sh_value_q[15:12] == '0); end
        endcase

        case (nib)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase

        ssd_ctl_d = ~(4'b0001 << idx_q);
        segs_d    = blank ? '1 : {~sh_dp_q[idx_q], seg7};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_value_q <= '0;
            sh_dp_q    <= '0;
            sh_lzb_q   <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            ssd_ctl_q  <= '1;
            segs_q     <= '1;
        end else begin
            sh_value_q <= sh_value_d;
            sh_dp_q    <= sh_dp_d;
            sh_lzb_q   <= sh_lzb_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            ssd_ctl_q  <= ssd_ctl_d;
            segs_q     <= segs_d;
        end
    end

    assign ssd_ctl = ssd_ctl_q;
    assign segs    = segs_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: edge-count based display model compared every cycle,
// plus literal expectations for reset, dp, blanking and tear-free loading.
module tb_ssd_scan_ctrl;

    localparam int unsigned RC = 4;
    localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  dp = '0;
    logic        lzb = 1'b0;
    logic [3:0]  ssd_ctl;
    logic [7:0]  segs;

    int checks = 0;
    int errors = 0;

    ssd_scan_ctrl #(.REFRESH_CNT(RC)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .dp(dp), .lzb(lzb), .ssd_ctl(ssd_ctl), .segs(segs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Displayed pattern for digit d given shadow contents.
    function automatic logic [7:0] render(input int d, input logic [15:0] v,
                                          input logic [3:0] dpv, input logic lz);
        logic [15:0] nib;
        nib = (v >> (4 * d)) & 16'hF;
        if (lz && d > 0 && (v >> (4 * d)) == 16'h0) return 8'hFF;
        return {~dpv[d], SEG[nib[3:0]][6:0]};
    endfunction

    // Model: after reset, edge number n (from 0) shows digit (n/RC)%4 built from
    // the shadow contents held before that edge.
    int          n;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_lzb;
    logic [3:0]  exp_ctl;
    logic [7:0]  exp_segs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 0; m_val <= '0; m_dp <= '0; m_lzb <= 1'b0;
            exp_ctl <= 4'hF; exp_segs <= 8'hFF;
        end else begin
            exp_ctl  <= ~(4'b0001 << ((n / RC) % 4));
            exp_segs <= render((n / RC) % 4, m_val, m_dp, m_lzb);
            if (load) begin
                m_val <= value; m_dp <= dp; m_lzb <= lzb;
            end
            n <= n + 1;
        end
    end

    logic       cmp_en = 1'b0;
    logic       chk_dwell = 1'b0;
    logic [3:0] dw_prev;
    int         dw_run;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ctl", 32'(ssd_ctl), 32'(exp_ctl));
            check("segs", 32'(segs), 32'(exp_segs));
        end
        if (chk_dwell) begin
            check("onehot", 32'($countones(~ssd_ctl)), 32'd1);
            if (ssd_ctl == dw_prev) dw_run++;
            else begin
                check("dwell", 32'(dw_run), 32'(RC));
                dw_prev = ssd_ctl;
                dw_run = 1;
            end
        end
    end

    logic [7:0] seen [4];

    task automatic capture_frame();
        for (int i = 0; i < 4 * int'(RC); i++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) if (!ssd_ctl[p]) seen[p] = segs;
        end
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] d, input logic l);
        @(negedge clk);
        value = v; dp = d; lzb = l; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4 * RC + 2) @(negedge clk);
    endtask

    logic [15:0] sweep [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    logic [3:0]  old_ctl;
    logic        found;

    initial begin
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_ctl", 32'(ssd_ctl), 32'h E);
        check("first_segs", 32'(segs), 32'h C0);

        for (int s = 0; s < 4; s++) begin
            load_val(sweep[s], 4'b0000, 1'b0);
            capture_frame();
            for (int p = 0; p < 4; p++)
                check("sweep", 32'(seen[p]), 32'(SEG[(sweep[s] >> (4 * p)) & 16'hF]));
        end

        load_val(16'h0000, 4'b0100, 1'b0);
        capture_frame();
        check("dp_d0", 32'(seen[0]), 32'h C0);
        check("dp_d1", 32'(seen[1]), 32'h C0);
        check("dp_d2", 32'(seen[2]), 32'h 40);
        check("dp_d3", 32'(seen[3]), 32'h C0);

        load_val(16'h0050, 4'b0000, 1'b1);
        capture_frame();
        check("lzb_d0", 32'(seen[0]), 32'h C0);
        check("lzb_d1", 32'(seen[1]), 32'h 92);
        check("lzb_d2", 32'(seen[2]), 32'h FF);
        check("lzb_d3", 32'(seen[3]), 32'h FF);

        load_val(16'h0000, 4'b1111, 1'b1);
        capture_frame();
        check("lz0_d0", 32'(seen[0]), 32'h 40);
        check("lz0_d1", 32'(seen[1]), 32'h FF);
        check("lz0_d2", 32'(seen[2]), 32'h FF);
        check("lz0_d3", 32'(seen[3]), 32'h FF);

        load_val(16'h3210, 4'b0000, 1'b0);
        @(negedge clk);
        value = 16'hFFFF; dp = 4'hF; lzb = 1'b1;
        capture_frame();
        check("hold_d0", 32'(seen[0]), 32'h C0);
        check("hold_d1", 32'(seen[1]), 32'h F9);
        check("hold_d2", 32'(seen[2]), 32'h A4);
        check("hold_d3", 32'(seen[3]), 32'h B0);

        found = 1'b0;
        for (int i = 0; i < int'(RC) + 1 && !found; i++) begin
            @(negedge clk);
            if (n % int'(RC) == int'(RC) - 1) found = 1'b1;
        end
        check("tear_align", 32'(found), 32'd1);
        old_ctl = ssd_ctl;
        value = 16'h8888; dp = 4'h0; lzb = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        check("tear_segs", 32'(segs), 32'h 80);
        check("tear_switch", 32'(ssd_ctl != old_ctl), 32'd1);

        #1;
        dw_prev = ssd_ctl;
        dw_run = 1;
        chk_dwell = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            value = 16'($urandom);
            dp = 4'($urandom);
            lzb = 1'($urandom);
            load = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        load = 1'b0;
        chk_dwell = 1'b0;

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ctl", 32'(ssd_ctl), 32'h F);
        check("rst_segs", 32'(segs), 32'h FF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ctl", 32'(ssd_ctl), 32'h E);
        check("rel_segs", 32'(segs), 32'h C0);
        repeat (4 * RC) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
